uart_cc_ctrl: RTL and testbench

Controller between the UART receiver and the UART transmitter in the case-converter path. It accepts received bytes and interprets in-band mode commands. Data bytes are case-converted according to the current mode and queued in a small FIFO. The block then sequences the transmitter, issuing one byte at a time through a start/busy handshake.

---
 rtl/uart_cc_pkg.sv | 26 ++
 rtl/cc_fifo.sv | 37 +++
 rtl/uart_cc_ctrl.sv | 76 +++++++
 tb/tb_uart_cc_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cc_pkg.sv
// uart_cc_pkg: shared encodings and the case-conversion rule for the UART case-converter path.
package uart_cc_pkg;
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_LOWER = 2'd2,
        MODE_SWAP  = 2'd3
    } mode_t;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;
    localparam logic [7:0] CMD_PASS  = 8'h11;
    localparam logic [7:0] CMD_UPPER = 8'h12;
    localparam logic [7:0] CMD_LOWER = 8'h13;
    localparam logic [7:0] CMD_SWAP  = 8'h14;
    function automatic logic [7:0] cc_convert(input logic [7:0] b, input mode_t m);
        logic lc, uc, to_up, to_lo;
        lc = b >= 8'h61 && b <= 8'h7a;
        uc = b >= 8'h41 && b <= 8'h5a;
        to_up = m == MODE_UPPER || m == MODE_SWAP;
        to_lo = m == MODE_LOWER || m == MODE_SWAP;
        return (lc && to_up) ? b - 8'h20 : (uc && to_lo) ? b + 8'h20 : b;
    endfunction
endpackage

// File: rtl/cc_fifo.sv
// cc_fifo: synchronous byte FIFO with occupancy count; rd_data shows the head entry.
module cc_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign rd = pop && !empty;
    // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
    assign wr = push && (!full || rd);
    assign full = level[AW];
    assign empty = level == '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge i_clk)
        if (wr) mem[wr_ptr] <= wr_data;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            level  <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/uart_cc_ctrl.sv
// uart_cc_ctrl: decodes mode commands, case-converts and queues rx bytes, and feeds the transmitter.
module uart_cc_ctrl
    import uart_cc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 4,
    parameter bit CMD_EN      = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_valid,
    input  logic                        i_tx_busy,
    input  logic                        i_ovf_clr,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_start,
    output logic [1:0]                  o_mode,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow,
    output logic                        o_ack_err
);
    localparam int CW = $clog2(ACK_TIMEOUT) + 1;
    state_t state, next;
    mode_t mode;
    logic [CW-1:0] cnt;
    logic [7:0] head, conv;
    logic is_cmd, push, pop, full, empty, timeout;
    assign is_cmd = CMD_EN && i_rx_data >= CMD_PASS && i_rx_data <= CMD_SWAP;
    assign push = i_rx_valid && !is_cmd;
    assign conv = cc_convert(i_rx_data, mode);
    assign o_mode = mode;
    cc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push    (push),
        .pop     (pop),
        .wr_data (conv),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (o_level)
    );
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= ST_IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            ST_IDLE:      next = (!empty && !i_tx_busy) ? ST_WAIT_ACK : ST_IDLE;
            ST_WAIT_ACK:  next = i_tx_busy ? ST_WAIT_DONE : timeout ? ST_IDLE : ST_WAIT_ACK;
            ST_WAIT_DONE: next = i_tx_busy ? ST_WAIT_DONE : ST_IDLE;
            default:      next = ST_IDLE;
        endcase
    end
    always_comb begin
        pop = state == ST_IDLE && !empty && !i_tx_busy;
        timeout = state == ST_WAIT_ACK && !i_tx_busy && cnt == CW'(ACK_TIMEOUT - 1);
    end
    // Command bytes 0x11..0x14 map to modes 0..3 through their low two bits minus one.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            mode       <= MODE_PASS;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            cnt        <= '0;
            o_overflow <= 1'b0;
            o_ack_err  <= 1'b0;
        end else begin
            if (i_rx_valid && is_cmd) mode <= mode_t'(i_rx_data[1:0] - 2'd1);
            if (pop) o_tx_data <= head;
            o_tx_start <= pop;
            cnt        <= (state == ST_WAIT_ACK) ? cnt + CW'(1) : '0;
            o_overflow <= (push && full && !pop) || (o_overflow && !i_ovf_clr);
            o_ack_err  <= timeout || (o_ack_err && !i_ovf_clr);
        end
endmodule

// File: tb/tb_uart_cc_ctrl.sv
// tb_uart_cc_ctrl: directed and randomized checks of uart_cc_ctrl against a queue-based model.
module tb_uart_cc_ctrl;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0, tx_busy = 1'b0, ovf_clr = 1'b0;
    logic [7:0] tx_data;
    logic tx_start, overflow, ack_err;
    logic [1:0] mode;
    logic [4:0] level;
    int vectors = 0, miscompares = 0, proto_err = 0;
    int ref_mode = 0, drops = 0, frame_len = 10, frame_cnt = 0;
    bit force_busy = 0, tx_ignore = 0, track = 0;
    logic [7:0] exp_q[$], got[$];
    logic [7:0] last_data = '0;

    always #5 clk = ~clk;

    uart_cc_ctrl #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(4), .CMD_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_tx_busy(tx_busy), .i_ovf_clr(ovf_clr), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_mode(mode), .o_level(level), .o_overflow(overflow), .o_ack_err(ack_err)
    );

    // Transmitter model: records every started byte and keeps busy high for frame_len cycles.
    always @(negedge clk) begin
        if (rst) begin
            frame_cnt = 0;
            last_data = tx_data;
        end else begin
            if (frame_cnt > 0) frame_cnt--;
            if (tx_start) begin
                if (tx_busy) proto_err++;
                got.push_back(tx_data);
                if (!tx_ignore) frame_cnt = frame_len;
            end else if (tx_data !== last_data) proto_err++;
            last_data = tx_data;
        end
        tx_busy = force_busy || frame_cnt > 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] ref_conv(input logic [7:0] b, input int m);
        if ((m == 1 || m == 3) && b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
        if ((m == 2 || m == 3) && b >= 8'h41 && b <= 8'h5a) return b + 8'h20;
        return b;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        if (b >= 8'h11 && b <= 8'h14) ref_mode = int'(b) - 'h11;
        else if (track && exp_q.size() >= DEPTH) drops++;
        else exp_q.push_back(ref_conv(b, ref_mode));
        step();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        do b = 8'($urandom); while (b >= 8'h11 && b <= 8'h14);
        return b;
    endfunction

    function automatic logic [7:0] rand_any();
        case ($urandom_range(0, 4))
            0: return 8'(8'h11 + $urandom_range(0, 3));
            1: return 8'(8'h41 + $urandom_range(0, 25));
            2: return 8'(8'h61 + $urandom_range(0, 25));
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while ((got.size() < exp_q.size() || level != 0 || tx_busy) && n < 3000) begin
            step();
            n++;
        end
        step(4);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_ackerr"}, ack_err, 0);
    endtask

    initial begin
        logic [7:0] b;
        int nd;
        step(2);
        @(negedge clk);
        check_reset("reset");
        step();
        rst = 1'b0;
        step(2);
        // Single byte latency and idle return
        frame_len = 10;
        send(8'h61);
        @(negedge clk);
        chk("lat_level", level, 1);
        chk("lat_nostart", tx_start, 0);
        step();
        @(negedge clk);
        chk("lat_start", tx_start, 1);
        chk("lat_data", tx_data, 8'h61);
        step();
        @(negedge clk);
        chk("lat_pulse", tx_start, 0);
        step(12);
        @(negedge clk);
        chk("lat_empty", level, 0);
        step();
        drain("lat");
        send(8'h62);
        step();
        @(negedge clk);
        chk("idle_start", tx_start, 1);
        step();
        drain("idle");
        // Mode commands
        frame_len = 3;
        send(8'h12); send(8'h61); send(8'h5a); send(8'h35);
        @(negedge clk);
        chk("mode_upper", mode, 1);
        step();
        drain("upper");
        send(8'h14); send(8'h61); send(8'h42);
        drain("swap");
        send(8'h11); send(8'h61); send(8'h42);
        drain("pass");
        chk("mode_pass", mode, 0);
        // Overflow with the transmitter held busy
        force_busy = 1;
        step(2);
        track = 1;
        drops = 0;
        for (int i = 0; i < DEPTH + 2; i++) send(rand_data());
        @(negedge clk);
        chk("ovf_level", level, DEPTH);
        chk("ovf_flag", overflow, 1);
        step();
        ovf_clr = 1'b1;
        send(rand_data());
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", overflow, 1);
        step();
        track = 0;
        force_busy = 0;
        drain("ovf_drain");
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clear", overflow, 0);
        step();
        // Push in the same cycle as a pop on a full FIFO
        force_busy = 1;
        step(2);
        for (int i = 0; i < DEPTH; i++) send(rand_data());
        @(negedge clk);
        chk("full_level", level, DEPTH);
        step();
        force_busy = 0;
        b = rand_data();
        send(b);
        @(negedge clk);
        chk("pp_level", level, DEPTH);
        chk("pp_ovf", overflow, 0);
        chk("pp_start", tx_start, 1);
        step();
        drain("pp_drain");
        // Acknowledge timeout
        tx_ignore = 1;
        send(8'h78);
        step();
        @(negedge clk);
        chk("tmo_start", tx_start, 1);
        step(3);
        @(negedge clk);
        chk("tmo_early", ack_err, 0);
        step();
        @(negedge clk);
        chk("tmo_err", ack_err, 1);
        step();
        tx_ignore = 0;
        send(8'h79);
        step();
        @(negedge clk);
        chk("tmo_next_start", tx_start, 1);
        step();
        drain("tmo_drain");
        // Randomized traffic at a sustainable rate
        for (int i = 0; i < 30; i++) begin
            frame_len = $urandom_range(1, 6);
            send(rand_any());
            step(frame_len + 6);
        end
        drain("rand");
        // Randomized bursts against a held transmitter
        for (int k = 0; k < 3; k++) begin
            force_busy = 1;
            step(2);
            track = 1;
            drops = 0;
            nd = $urandom_range(8, 22);
            for (int i = 0; i < nd; i++) send(rand_any());
            @(negedge clk);
            chk("burst_level", level, exp_q.size());
            chk("burst_ovf", overflow, drops > 0);
            chk("burst_mode", mode, ref_mode);
            step();
            track = 0;
            force_busy = 0;
            drain("burst");
            ovf_clr = 1'b1;
            step();
            ovf_clr = 1'b0;
        end
        // Reset while a frame is in progress
        frame_len = 20;
        send(8'h12); send(8'h61); send(8'h62); send(8'h63);
        step(5);
        @(negedge clk);
        chk("mid_level", level, 2);
        chk("mid_mode", mode, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        step();
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        ref_mode = 0;
        step(30);
        chk("no_retx", got.size(), 0);
        chk("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
